// File: rtl/eer_pkg.sv
// Shared constants and FSM encoding for the EER-RL routing datapath blocks.
package eer_pkg;
    localparam int WORD_WIDTH = 16;
    localparam int MEM_DEPTH  = 64;
    localparam int IDX_WIDTH  = 6;
    localparam int CNT_WIDTH  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } qscan_state_t;
endpackage

// File: rtl/qscan_cmp.sv
// Registered running-maximum stage: keeps the first index holding the largest value seen.
// QSCAN_SKIP_ZERO_EN: zero-valued entries are treated as empty and never win.
module qscan_cmp #(
    parameter int WORD_WIDTH = eer_pkg::WORD_WIDTH,
    parameter int IDX_WIDTH  = eer_pkg::IDX_WIDTH
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clear,
    input  logic                  vld,
    input  logic [IDX_WIDTH-1:0]  idx,
    input  logic [WORD_WIDTH-1:0] data,
    output logic                  found,
    output logic [IDX_WIDTH-1:0]  best_index,
    output logic [WORD_WIDTH-1:0] best_q
);
    logic eligible;
    logic update;

`ifdef QSCAN_SKIP_ZERO_EN
    assign eligible = vld && (data != '0);
`else
    assign eligible = vld;
`endif

    // Strictly greater: a later equal value never displaces the lower index.
    assign update = eligible && (!found || (data > best_q));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            found      <= 1'b0;
            best_index <= '0;
            best_q     <= '0;
        end else if (clear) begin
            found      <= 1'b0;
            best_index <= '0;
            best_q     <= '0;
        end else if (update) begin
            found      <= 1'b1;
            best_index <= idx;
            best_q     <= data;
        end
    end
endmodule

// File: rtl/node_qscan.sv
// Scans the node memory bank for the entry with the largest Q-value among the first node_count.
// QSCAN_SKIP_ZERO_EN (see qscan_cmp): zero entries are ignored as empty.
module node_qscan #(
    parameter int WORD_WIDTH = eer_pkg::WORD_WIDTH,
    parameter int MEM_DEPTH  = eer_pkg::MEM_DEPTH,
    parameter int IDX_WIDTH  = eer_pkg::IDX_WIDTH
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           start,
    input  logic [eer_pkg::CNT_WIDTH-1:0]  node_count,
    input  logic [WORD_WIDTH-1:0]          mem_data,
    output logic [IDX_WIDTH-1:0]           mem_index,
    output logic                           busy,
    output logic                           done,
    output logic                           found,
    output logic [IDX_WIDTH-1:0]           best_index,
    output logic [WORD_WIDTH-1:0]          best_q
);
    import eer_pkg::*;

    qscan_state_t         state;
    logic [IDX_WIDTH-1:0] last_idx;
    logic [CNT_WIDTH-1:0] n_clamp;
    logic                 accept;
    logic                 vld_p0;
    logic                 vld_p1;
    logic [IDX_WIDTH-1:0] idx_p1;

    assign accept  = start && (state == ST_IDLE);
    assign n_clamp = (node_count > CNT_WIDTH'(MEM_DEPTH)) ? CNT_WIDTH'(MEM_DEPTH) : node_count;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            mem_index <= '0;
            last_idx  <= '0;
            vld_p0    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        last_idx <= IDX_WIDTH'(n_clamp - CNT_WIDTH'(1));
                        if (n_clamp != '0) begin
                            state     <= ST_SCAN;
                            mem_index <= '0;
                            vld_p0    <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_SCAN: begin
                    if (mem_index == last_idx) begin
                        state  <= ST_DRAIN;
                        vld_p0 <= 1'b0;
                    end else begin
                        mem_index <= mem_index + IDX_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    // vld_p1 high here means the last read is being compared on this edge.
                    if (vld_p1) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // p0 -> p1: index travels with its read so the returning word is tagged correctly.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        idx_p1 <= mem_index;
    end

    qscan_cmp #(
        .WORD_WIDTH (WORD_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_cmp (
        .clk        (clk),
        .nrst       (nrst),
        .clear      (accept),
        .vld        (vld_p1),
        .idx        (idx_p1),
        .data       (mem_data),
        .found      (found),
        .best_index (best_index),
        .best_q     (best_q)
    );
endmodule

// File: doc/node_qscan.md
# node_qscan

Scans the 64-entry node memory bank (16-bit words, 6-bit index, synchronous read) and returns the index and value of the entry holding the largest Q-value among the first `node_count` entries. It sits directly downstream of the node memory bank, driving its read index and consuming its `data_out`. Its result feeds next-hop selection in the EER-RL routing datapath.

## Interface
Parameters:
- `WORD_WIDTH`, 16: width of a memory word (Q-value, unsigned).
- `MEM_DEPTH`, 64: number of memory entries.
- `IDX_WIDTH`, 6: log2(MEM_DEPTH).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `nrst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a scan; ignored unless idle.
- `node_count`  in  7  entries to scan (0..64); values above 64 are clamped to 64; sampled at the accepted `start`.
- `mem_data`  in  WORD_WIDTH  memory bank `data_out`; valid one clock after `mem_index` is presented.
- `mem_index`  out  IDX_WIDTH  read index to the memory bank.
- `busy`  out  1  high from the accepted start until `done`.
- `done`  out  1  one-cycle pulse when results are valid.
- `found`  out  1  at least one eligible entry was seen.
- `best_index`  out  IDX_WIDTH  index of the winning entry.
- `best_q`  out  WORD_WIDTH  value of the winning entry.

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE: `start`=1 with `node_count`≠0 → SCAN, `mem_index`=0, clear the running best and `found`. `start`=1 with `node_count`=0 → DONE directly, with `found`=0, `best_index`=0 and `best_q`=0.
- SCAN: `mem_index` increments by 1 each cycle up to `node_count`−1, then → DRAIN. A one-bit issue-valid register and a captured index accompany each read so that `mem_data` is compared against the index that produced it.
- Compare rule: update the best when data is valid and either `found`=0 or `mem_data` > `best_q` (strictly greater, unsigned). Ties keep the lower index.
- DRAIN: stay until the compare of the last issued index has completed, then → DONE.
- DONE: assert `done` for one cycle, then → IDLE.
- `best_index`, `best_q` and `found` hold their values until the next accepted start.
- `start` while `busy` is ignored and has no effect on the current scan.
- `mem_index` holds its last value in DRAIN, DONE and IDLE. The memory index is never wrapped: the maximum issued index is 63.

## Timing
- Reset values: `mem_index`=0, `busy`=0, `done`=0, `found`=0, `best_index`=0, `best_q`=0; state = IDLE.
- Start accepted at edge E0. Index k is presented after edge Ek, its data is visible after Ek+1, and it is compared at Ek+2.
- `done` is high in the cycle after edge E(N+2), where N is the clamped `node_count`.
- When N=0, `done` is high in the cycle after E1.
- `busy` is high from after E0 through the cycle in which `done` is high.
- A new `start` is accepted no earlier than the cycle after `done`.
- Deasserting `nrst` mid-scan immediately forces the reset values. No partial result is retained.

## Configuration
- `QSCAN_SKIP_ZERO_EN` defined: an entry whose value is 0 is treated as empty and never becomes the best. If all entries are 0, `found`=0 and `best_q`=0.
- Undefined: every entry is eligible. `found`=1 whenever N≥1, including the case where all entries are 0 (then `best_index`=0).

## Structure
- The shared package `eer_pkg` holds `WORD_WIDTH`, `MEM_DEPTH`, `IDX_WIDTH`, the FSM state encoding, and the `node_count` width constant.
- Sub-module `qscan_cmp` is a registered compare/update stage (valid, index, data in; best, found out). It is the natural point for later reuse in the cluster-head selector.

## Test plan
- Memory preloaded with value 3 at index 0 and 15 at index 1, N=2 → `best_index`=1, `best_q`=15, `found`=1, `done` in the cycle after E4.
- Value 100 at indices 5 and 9, all others below 100, N=64 → `best_index`=5 (tie keeps lower index), `done` in the cycle after E66.
- N=0 → `done` after E1, `found`=0; `mem_index` stays 0.
- All entries 0, N=8 → with `QSCAN_SKIP_ZERO_EN`: `found`=0; without it: `found`=1 and `best_index`=0.
- `start` pulsed again mid-scan with N=70 → first scan unaffected, clamped to 64, maximum `mem_index`=63.
- `nrst` dropped at scan cycle 10 → all outputs return to 0 asynchronously. A fresh start afterwards yields the correct result.
